// File: rtl/rv64g_l2_line_xfer.sv
// L2 line-transfer sequencer: FILL streams 8 refill beats into one way and then installs the tag;
// EVICT reads one way out as a back-pressured beat stream along with its stored tag.
module rv64g_l2_line_xfer #(
    parameter int DATA_W = 64,
    parameter int TAG_W  = 50,
    parameter int IDX_W  = 8,
    parameter int WAY_W  = 4,
    parameter int WORDS  = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic                       req_op_i,
    input  logic [IDX_W-1:0]           req_index_i,
    input  logic [WAY_W-1:0]           req_way_i,
    input  logic [TAG_W-1:0]           req_tag_i,
    input  logic                       fill_valid_i,
    output logic                       fill_ready_o,
    input  logic [DATA_W-1:0]          fill_data_i,
    output logic                       ev_valid_o,
    input  logic                       ev_ready_i,
    output logic [DATA_W-1:0]          ev_data_o,
    output logic                       ev_last_o,
    output logic [TAG_W-1:0]           ev_tag_o,
    output logic [IDX_W-1:0]           arr_index_o,
    output logic [$clog2(WORDS)-1:0]   arr_word_o,
    output logic [WAY_W-1:0]           arr_way_o,
    output logic                       arr_data_we_o,
    output logic                       arr_tag_we_o,
    output logic [DATA_W/8-1:0]        arr_be_o,
    output logic [DATA_W-1:0]          arr_wdata_o,
    output logic [TAG_W-1:0]           arr_tag_o,
    input  logic [DATA_W-1:0]          arr_rdata_i,
    input  logic [TAG_W-1:0]           arr_tag_i,
    output logic                       busy_o,
    output logic                       done_o
);

    localparam int WORD_W = $clog2(WORDS);
    localparam int CNT_W  = WORD_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FTAG,
        S_EVICT,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [CNT_W-1:0]    wr_cnt_reg;
    logic [CNT_W-1:0]    rd_cnt_reg;
    logic [IDX_W-1:0]    index_reg;
    logic [WAY_W-1:0]    way_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic                ev_valid_reg;
    logic                ev_last_reg;
    logic [DATA_W-1:0]   ev_data_reg;
    logic [TAG_W-1:0]    ev_tag_reg;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= S_IDLE;
            wr_cnt_reg   <= '0;
            rd_cnt_reg   <= '0;
            index_reg    <= '0;
            way_reg      <= '0;
            tag_reg      <= '0;
            ev_valid_reg <= 1'b0;
            ev_last_reg  <= 1'b0;
            ev_data_reg  <= '0;
            ev_tag_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req_valid_i) begin
                        index_reg  <= req_index_i;
                        way_reg    <= req_way_i;
                        tag_reg    <= req_tag_i;
                        wr_cnt_reg <= '0;
                        rd_cnt_reg <= '0;
                        if (req_op_i) begin
                            // Array address passes the request through while idle, so this is the target tag.
                            ev_tag_reg <= arr_tag_i;
                            state_reg  <= S_EVICT;
                        end else begin
                            state_reg  <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (fill_valid_i) begin
                        wr_cnt_reg <= wr_cnt_reg + 1'b1;
                        if (wr_cnt_reg == CNT_LAST) begin
                            state_reg <= S_FTAG;
                        end
                    end
                end
                S_FTAG: begin
                    state_reg <= S_DONE;
                end
                S_EVICT: begin
                    if (ev_valid_reg && ev_ready_i && ev_last_reg) begin
                        ev_valid_reg <= 1'b0;
                        state_reg    <= S_DONE;
                    end else if ((!ev_valid_reg || ev_ready_i) && (rd_cnt_reg < CNT_FULL)) begin
                        ev_data_reg  <= arr_rdata_i;
                        ev_last_reg  <= (rd_cnt_reg == CNT_LAST);
                        ev_valid_reg <= 1'b1;
                        rd_cnt_reg   <= rd_cnt_reg + 1'b1;
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o   = (state_reg == S_IDLE);
    assign fill_ready_o  = (state_reg == S_FILL);
    assign arr_data_we_o = (state_reg == S_FILL) && fill_valid_i;
    assign arr_tag_we_o  = (state_reg == S_FTAG);
    assign busy_o        = (state_reg != S_IDLE);
    assign done_o        = (state_reg == S_DONE);

    assign arr_index_o = (state_reg == S_IDLE) ? req_index_i : index_reg;
    assign arr_way_o   = (state_reg == S_IDLE) ? req_way_i   : way_reg;
    assign arr_word_o  = (state_reg == S_EVICT) ? rd_cnt_reg[WORD_W-1:0] : wr_cnt_reg[WORD_W-1:0];
    assign arr_be_o    = '1;
    assign arr_wdata_o = fill_data_i;
    assign arr_tag_o   = tag_reg;

    assign ev_valid_o = ev_valid_reg;
    assign ev_data_o  = ev_data_reg;
    assign ev_last_o  = ev_last_reg;
    assign ev_tag_o   = ev_tag_reg;

endmodule

// File: tb/tb_rv64g_l2_line_xfer.sv
// Directed bench for rv64g_l2_line_xfer with a behavioural L2 data/tag array attached.
module tb_rv64g_l2_line_xfer;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [7:0]   req_index;
    logic [3:0]   req_way;
    logic [49:0]  req_tag;
    logic         fill_valid;
    logic         fill_ready;
    logic [63:0]  fill_data;
    logic         ev_valid;
    logic         ev_ready;
    logic [63:0]  ev_data;
    logic         ev_last;
    logic [49:0]  ev_tag;
    logic [7:0]   arr_index;
    logic [2:0]   arr_word;
    logic [3:0]   arr_way;
    logic         arr_data_we;
    logic         arr_tag_we;
    logic [7:0]   arr_be;
    logic [63:0]  arr_wdata;
    logic [49:0]  arr_tag;
    logic [63:0]  arr_rdata;
    logic [49:0]  arr_tag_rd;
    logic         busy;
    logic         done;

    rv64g_l2_line_xfer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_op_i      (req_op),
        .req_index_i   (req_index),
        .req_way_i     (req_way),
        .req_tag_i     (req_tag),
        .fill_valid_i  (fill_valid),
        .fill_ready_o  (fill_ready),
        .fill_data_i   (fill_data),
        .ev_valid_o    (ev_valid),
        .ev_ready_i    (ev_ready),
        .ev_data_o     (ev_data),
        .ev_last_o     (ev_last),
        .ev_tag_o      (ev_tag),
        .arr_index_o   (arr_index),
        .arr_word_o    (arr_word),
        .arr_way_o     (arr_way),
        .arr_data_we_o (arr_data_we),
        .arr_tag_we_o  (arr_tag_we),
        .arr_be_o      (arr_be),
        .arr_wdata_o   (arr_wdata),
        .arr_tag_o     (arr_tag),
        .arr_rdata_i   (arr_rdata),
        .arr_tag_i     (arr_tag_rd),
        .busy_o        (busy),
        .done_o        (done)
    );

    localparam logic [49:0] TAG_A = 50'h3_0000_0000_0ABC;

    logic [63:0] mem [0:255][0:15][0:7];
    logic [49:0] tag_mem [0:255][0:15];

    int           cyc;
    int           tag_we_cnt;
    int           done_cnt;
    int           n_cmp;
    int           n_bad;
    logic [2:0]   wlog_word [$];
    logic [63:0]  wlog_data [$];
    logic [11:0]  wlog_loc [$];
    logic [63:0]  evq_data [$];
    logic         evq_last [$];
    int           evq_cyc [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int s, input int w, input int k);
        return 64'hDEAD_0000_0000_0000 | 64'(s * 256 + w * 16 + k);
    endfunction

    assign arr_rdata  = mem[arr_index][arr_way][arr_word];
    assign arr_tag_rd = tag_mem[arr_index][arr_way];

    // Array model: synchronous writes, combinational reads; also logs every write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (arr_data_we) begin
            mem[arr_index][arr_way][arr_word] <= arr_wdata;
            wlog_word.push_back(arr_word);
            wlog_data.push_back(arr_wdata);
            wlog_loc.push_back({arr_index, arr_way});
        end
        if (arr_tag_we) begin
            tag_mem[arr_index][arr_way] <= arr_tag;
            tag_we_cnt <= tag_we_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic clear_logs();
        wlog_word.delete();
        wlog_data.delete();
        wlog_loc.delete();
        evq_data.delete();
        evq_last.delete();
        evq_cyc.delete();
    endtask

    task automatic run_fill(input logic [7:0] idx, input logic [3:0] way, input logic [49:0] tag,
                            input logic [63:0] base, input bit gaps, output int lat);
        int start;
        int k;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 1'b0; req_index = idx; req_way = way; req_tag = tag;
        start = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        lat = -1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            if (k < 8 && (!gaps || (c % 2 == 1))) begin
                fill_valid = 1'b1; fill_data = base + 64'(k);
            end else begin
                fill_valid = 1'b0;
            end
            @(negedge clk);
            if (fill_valid && fill_ready) k++;
            if (done) lat = cyc - start;
            @(posedge clk); #1;
        end
        fill_valid = 1'b0;
        $display("fill idx=%02h way=%0d base=%h gaps=%0d latency=%0d", idx, way, base, gaps, lat);
    endtask

    task automatic run_evict(input logic [7:0] idx, input logic [3:0] way, input logic [63:0] exp_base,
                             input int stall_beat, input int stall_len, output int start, output int lat);
        int got;
        int held;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 1'b1; req_index = idx; req_way = way; ev_ready = 1'b1;
        start = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0;
        got = 0; held = 0; lat = -1;
        for (int c = 0; c < 60 && lat < 0; c++) begin
            if (ev_valid && got == stall_beat && held < stall_len) begin
                ev_ready = 1'b0; held++;
            end else begin
                ev_ready = 1'b1;
            end
            @(negedge clk);
            if (ev_valid && !ev_ready) begin
                n_cmp++;
                if (ev_data !== exp_base + 64'(got)) begin
                    n_bad++;
                    $display("FAIL evict_hold beat %0d: got %h expected %h", got, ev_data, exp_base + 64'(got));
                end
            end
            if (ev_valid && ev_ready) begin
                evq_data.push_back(ev_data);
                evq_last.push_back(ev_last);
                evq_cyc.push_back(cyc - start);
                got++;
            end
            if (done) lat = cyc - start;
            @(posedge clk); #1;
        end
        ev_ready = 1'b1;
        $display("evict idx=%02h way=%0d beats=%0d stall_len=%0d latency=%0d", idx, way, got, stall_len, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid); end
        n_cmp++; if (ev_data !== 64'h0) begin n_bad++; $display("FAIL reset_ev_data: got %h expected 0", ev_data); end
        n_cmp++; if (ev_tag !== 50'h0) begin n_bad++; $display("FAIL reset_ev_tag: got %h expected 0", ev_tag); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if ({fill_ready, arr_data_we, arr_tag_we} !== 3'b000) begin
            n_bad++; $display("FAIL reset_enables: got %b expected 000", {fill_ready, arr_data_we, arr_tag_we});
        end
        n_cmp++; if (arr_tag !== 50'h0) begin n_bad++; $display("FAIL reset_arr_tag: got %h expected 0", arr_tag); end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_fill_b2b();
        int lat;
        clear_logs();
        tag_we_cnt = 0; done_cnt = 0;
        run_fill(8'h12, 4'd5, TAG_A, 64'hA0, 1'b0, lat);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL fill_latency: got %0d expected 10", lat); end
        n_cmp++; if (wlog_word.size() !== 8) begin n_bad++; $display("FAIL fill_write_count: got %0d expected 8", wlog_word.size()); end
        for (int i = 0; i < 8 && i < wlog_word.size(); i++) begin
            n_cmp++;
            if (wlog_word[i] !== 3'(i) || wlog_data[i] !== 64'hA0 + 64'(i) || wlog_loc[i] !== 12'h125) begin
                n_bad++;
                $display("FAIL fill_write_%0d: got word %0d data %h loc %h expected word %0d data %h loc 125",
                         i, wlog_word[i], wlog_data[i], wlog_loc[i], i, 64'hA0 + 64'(i));
            end
        end
        n_cmp++; if (tag_we_cnt !== 1) begin n_bad++; $display("FAIL fill_tag_we: got %0d expected 1", tag_we_cnt); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL fill_done_count: got %0d expected 1", done_cnt); end
        n_cmp++; if (tag_mem[8'h12][4'd5] !== TAG_A) begin
            n_bad++; $display("FAIL fill_tag_array: got %h expected %h", tag_mem[8'h12][4'd5], TAG_A);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem[8'h12][4'd5][i] !== 64'hA0 + 64'(i)) begin
                n_bad++; $display("FAIL fill_readback_%0d: got %h expected %h", i, mem[8'h12][4'd5][i], 64'hA0 + 64'(i));
            end
        end
    endtask

    task automatic test_fill_gaps();
        int lat;
        clear_logs();
        tag_we_cnt = 0;
        run_fill(8'h34, 4'd2, 50'h1_2345, 64'hB0, 1'b1, lat);
        n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL gap_latency: got %0d expected 18", lat); end
        n_cmp++; if (wlog_word.size() !== 8) begin n_bad++; $display("FAIL gap_write_count: got %0d expected 8", wlog_word.size()); end
        for (int i = 0; i < 8 && i < wlog_word.size(); i++) begin
            n_cmp++;
            if (wlog_word[i] !== 3'(i) || wlog_data[i] !== 64'hB0 + 64'(i)) begin
                n_bad++;
                $display("FAIL gap_write_%0d: got word %0d data %h expected word %0d data %h",
                         i, wlog_word[i], wlog_data[i], i, 64'hB0 + 64'(i));
            end
        end
        n_cmp++; if (tag_we_cnt !== 1) begin n_bad++; $display("FAIL gap_tag_we: got %0d expected 1", tag_we_cnt); end
    endtask

    task automatic test_evict();
        int start;
        int lat;
        clear_logs();
        run_evict(8'h12, 4'd5, 64'hA0, -1, 0, start, lat);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL evict_latency: got %0d expected 10", lat); end
        n_cmp++; if (evq_data.size() !== 8) begin n_bad++; $display("FAIL evict_beats: got %0d expected 8", evq_data.size()); end
        for (int i = 0; i < 8 && i < evq_data.size(); i++) begin
            n_cmp++;
            if (evq_data[i] !== 64'hA0 + 64'(i) || evq_last[i] !== (i == 7) || evq_cyc[i] !== 2 + i) begin
                n_bad++;
                $display("FAIL evict_beat_%0d: got data %h last %b cycle %0d expected data %h last %b cycle %0d",
                         i, evq_data[i], evq_last[i], evq_cyc[i], 64'hA0 + 64'(i), (i == 7), 2 + i);
            end
        end
        n_cmp++; if (ev_tag !== TAG_A) begin n_bad++; $display("FAIL evict_tag: got %h expected %h", ev_tag, TAG_A); end
        n_cmp++; if (ev_valid !== 1'b0) begin n_bad++; $display("FAIL evict_valid_clear: got %b expected 0", ev_valid); end
    endtask

    task automatic test_evict_stall();
        int start;
        int lat;
        clear_logs();
        run_evict(8'h12, 4'd5, 64'hA0, 3, 5, start, lat);
        n_cmp++; if (lat !== 15) begin n_bad++; $display("FAIL stall_latency: got %0d expected 15", lat); end
        n_cmp++; if (evq_data.size() !== 8) begin n_bad++; $display("FAIL stall_beats: got %0d expected 8", evq_data.size()); end
        for (int i = 0; i < 8 && i < evq_data.size(); i++) begin
            n_cmp++;
            if (evq_data[i] !== 64'hA0 + 64'(i) || evq_last[i] !== (i == 7)) begin
                n_bad++;
                $display("FAIL stall_beat_%0d: got data %h last %b expected data %h last %b",
                         i, evq_data[i], evq_last[i], 64'hA0 + 64'(i), (i == 7));
            end
        end
    endtask

    task automatic test_busy_req();
        int start;
        int lat;
        int k;
        int got;
        clear_logs();
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 1'b0; req_index = 8'h40; req_way = 4'd1; req_tag = 50'h155;
        start = cyc;
        @(posedge clk); #1;
        req_op = 1'b1; req_index = 8'h12; req_way = 4'd5;
        k = 0; lat = -1;
        for (int c = 0; c < 40 && lat < 0; c++) begin
            fill_valid = (k < 8);
            fill_data = 64'hE0 + 64'(k);
            @(negedge clk);
            n_cmp++;
            if (req_ready !== 1'b0) begin n_bad++; $display("FAIL busy_req_ready cycle %0d: got %b expected 0", c, req_ready); end
            if (fill_valid && fill_ready) k++;
            if (done) lat = cyc - start;
            @(posedge clk); #1;
        end
        fill_valid = 1'b0;
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL busy_fill_latency: got %0d expected 10", lat); end
        @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_accept_window: got ready %b busy %b expected ready 1 busy 0", req_ready, busy);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_after_accept: got %b expected 1", busy); end
        n_cmp++; if (ev_tag !== TAG_A) begin n_bad++; $display("FAIL busy_evict_tag: got %h expected %h", ev_tag, TAG_A); end
        got = 0;
        for (int c = 0; c < 30 && busy; c++) begin
            @(negedge clk);
            if (ev_valid && ev_ready) begin
                n_cmp++;
                if (ev_data !== 64'hA0 + 64'(got)) begin
                    n_bad++; $display("FAIL busy_evict_beat_%0d: got %h expected %h", got, ev_data, 64'hA0 + 64'(got));
                end
                got++;
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (got !== 8 || busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_evict_complete: got beats %0d busy %b expected 8 and 0", got, busy);
        end
        n_cmp++; if (wlog_loc.size() !== 8 || mem[8'h40][4'd1][7] !== 64'hE7 || mem[8'h40][4'd1][0] !== 64'hE0) begin
            n_bad++; $display("FAIL busy_fill_target: got writes %0d w0 %h w7 %h expected 8 e0 e7",
                              wlog_loc.size(), mem[8'h40][4'd1][0], mem[8'h40][4'd1][7]);
        end
        $display("busy request test: fill latency %0d, evict beats %0d", lat, got);
    endtask

    task automatic test_reset_abort();
        int k;
        clear_logs();
        tag_we_cnt = 0; done_cnt = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = 1'b0; req_index = 8'h55; req_way = 4'd7; req_tag = 50'h2_0000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (k = 0; k < 4; k++) begin
            fill_valid = 1'b1; fill_data = 64'hC0 + 64'(k);
            @(posedge clk); #1;
        end
        fill_data = 64'hC4;
        rst = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || fill_ready !== 1'b0) begin
            n_bad++; $display("FAIL abort_state: got busy %b fill_ready %b expected 0 0", busy, fill_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        fill_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL abort_done: got %0d expected 0", done_cnt); end
        n_cmp++; if (tag_we_cnt !== 0) begin n_bad++; $display("FAIL abort_tag_we: got %0d expected 0", tag_we_cnt); end
        n_cmp++; if (wlog_word.size() !== 4) begin n_bad++; $display("FAIL abort_write_count: got %0d expected 4", wlog_word.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [63:0] exp;
            exp = (i < 4) ? 64'hC0 + 64'(i) : init_word(8'h55, 7, i);
            n_cmp++;
            if (mem[8'h55][4'd7][i] !== exp) begin
                n_bad++; $display("FAIL abort_word_%0d: got %h expected %h", i, mem[8'h55][4'd7][i], exp);
            end
        end
        n_cmp++; if (tag_mem[8'h55][4'd7] !== 50'h0) begin
            n_bad++; $display("FAIL abort_tag_array: got %h expected 0", tag_mem[8'h55][4'd7]);
        end
        $display("reset abort test: %0d words written before reset", wlog_word.size());
    endtask

    initial begin
        cyc = 0; tag_we_cnt = 0; done_cnt = 0; n_cmp = 0; n_bad = 0;
        for (int s = 0; s < 256; s++) begin
            for (int w = 0; w < 16; w++) begin
                tag_mem[s][w] = 50'h0;
                for (int k = 0; k < 8; k++) mem[s][w][k] = init_word(s, w, k);
            end
        end
        rst = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_index = 8'h0; req_way = 4'h0; req_tag = 50'h0;
        fill_valid = 1'b0; fill_data = 64'h0; ev_ready = 1'b1;
        test_reset();
        test_fill_b2b();
        test_fill_gaps();
        test_evict();
        test_evict_stall();
        test_busy_req();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
